// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared LSU definitions: access size encodings, AXI response code, alignment helper.
package ysyx_25010008_lsu_pkg;

    localparam logic [1:0] SZ_B      = 2'd0;
    localparam logic [1:0] SZ_H      = 2'd1;
    localparam logic [1:0] SZ_W      = 2'd2;
    localparam logic       RESP_OKAY = 1'b0;

    // Size code 3 falls into the word case on purpose.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_align.sv
// Byte-lane steering: store data/strobe shift and load extract + sign/zero extension.
// Latency: purely combinational.
// Backpressure: none, no state.
module ysyx_25010008_lsu_align
    import ysyx_25010008_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [3:0]  strb_base;
    logic [31:0] ld_shift;

    always_comb begin
        case (st_size)
            SZ_B:    strb_base = 4'b0001;
            SZ_H:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
        st_wstrb = strb_base << st_off;
        st_wdata = st_data << {st_off, 3'b000};
    end

    always_comb begin
        ld_shift = ld_raw >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = ld_unsigned ? {24'b0, ld_shift[7:0]}
                                           : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = ld_unsigned ? {16'b0, ld_shift[15:0]}
                                           : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit bridging EXU requests to an AXI-lite master, one transaction at a time.
// Latency: load >= 3 cycles accept-to-out_valid; misaligned rejects answer 1 cycle after accept.
// Backpressure: in_ready only in IDLE; response held in RESP until out_ready.
module ysyx_25010008_lsu
    import ysyx_25010008_lsu_pkg::*;
#(
    parameter int unsigned CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic        rresp,
    input  logic        rvalid,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [31:0] wstrb,
    output logic        wvalid,
    input  logic        wready,
    output logic        bready,
    input  logic        bresp,
    input  logic        bvalid
);

    typedef enum logic [2:0] {
        IDLE, RADDR, RDATA, WADDR_DATA, WRESP, RESP
    } state_t;

    state_t      state, state_nxt;
    logic        aw_done, aw_done_nxt;
    logic        w_done, w_done_nxt;
    logic        accept, reject;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [3:0]  wstrb_q;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

    ysyx_25010008_lsu_align u_align (
        .st_off      (in_addr[1:0]),
        .st_size     (in_size),
        .st_data     (in_wdata),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_off      (addr_q[1:0]),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_raw      (rdata),
        .ld_data     (ld_data)
    );

    assign in_ready = (state == IDLE);
    assign araddr   = {addr_q[31:2], 2'b00};
    assign awaddr   = {addr_q[31:2], 2'b00};
    assign wstrb    = {28'b0, wstrb_q};

    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        accept      = 1'b0;
        reject      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    reject = (CHECK_ALIGN != 0) && misaligned(in_size, in_addr[1:0]);
                    if (reject)      state_nxt = RESP;
                    else if (in_wen) state_nxt = WADDR_DATA;
                    else             state_nxt = RADDR;
                end
            end
            RADDR: if (arready) state_nxt = RDATA;
            RDATA: if (rvalid)  state_nxt = RESP;
            WADDR_DATA: begin
                if (awvalid && awready) aw_done_nxt = 1'b1;
                if (wvalid && wready)   w_done_nxt  = 1'b1;
                if (aw_done_nxt && w_done_nxt) begin
                    state_nxt   = WRESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            WRESP: if (bvalid)    state_nxt = RESP;
            RESP:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are flops loaded from the next state, so AXI inputs never reach them combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            out_valid  <= 1'b0;
            out_rdata  <= 32'b0;
            out_err    <= 1'b0;
            addr_q     <= 32'b0;
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            wdata      <= 32'b0;
            wstrb_q    <= 4'b0;
        end else begin
            state     <= state_nxt;
            aw_done   <= aw_done_nxt;
            w_done    <= w_done_nxt;
            arvalid   <= (state_nxt == RADDR);
            rready    <= (state_nxt == RDATA);
            awvalid   <= (state_nxt == WADDR_DATA) && !aw_done_nxt;
            wvalid    <= (state_nxt == WADDR_DATA) && !w_done_nxt;
            bready    <= (state_nxt == WRESP);
            out_valid <= (state_nxt == RESP);
            if (accept) begin
                addr_q     <= in_addr;
                size_q     <= in_size;
                unsigned_q <= in_unsigned;
                if (in_wen) begin
                    wdata   <= st_wdata;
                    wstrb_q <= st_wstrb;
                end
                if (reject) begin
                    out_rdata <= 32'b0;
                    out_err   <= 1'b1;
                end
            end
            if (state == RDATA && rvalid) begin
                out_rdata <= ld_data;
                out_err   <= (rresp != RESP_OKAY);
            end
            if (state == WRESP && bvalid) begin
                out_rdata <= 32'b0;
                out_err   <= (bresp != RESP_OKAY);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Directed bench for the LSU: bench plays the AXI-lite slave cycle by cycle.
module tb_ysyx_25010008_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen, in_unsigned;
    logic [31:0] in_addr, in_wdata;
    logic [1:0]  in_size;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata, wstrb;
    logic        arvalid, arready, rready, rresp, rvalid;
    logic        awvalid, awready, wvalid, wready, bready, bresp, bvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_25010008_lsu #(.CHECK_ALIGN(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready), .bready(bready), .bresp(bresp), .bvalid(bvalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] rd, input logic [31:0] exp_araddr,
                           input logic [31:0] exp_d);
        in_valid = 1'b1; in_wen = 1'b0; in_addr = a; in_size = sz; in_unsigned = uns;
        tick;
        in_valid = 1'b0;
        chk({tag, ".arvalid"}, arvalid, 1);
        chk({tag, ".araddr"}, araddr, exp_araddr);
        chk({tag, ".in_ready"}, in_ready, 0);
        arready = 1'b1;
        tick;
        arready = 1'b0;
        chk({tag, ".arvalid_drop"}, arvalid, 0);
        chk({tag, ".rready"}, rready, 1);
        rvalid = 1'b1; rdata = rd; rresp = 1'b0;
        tick;
        rvalid = 1'b0;
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".out_rdata"}, out_rdata, exp_d);
        chk({tag, ".out_err"}, out_err, 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, ".idle"}, in_ready, 1);
    endtask

    task automatic store_op(input string tag, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd, input logic br, input logic [31:0] exp_awaddr,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_wstrb);
        in_valid = 1'b1; in_wen = 1'b1; in_addr = a; in_size = sz; in_wdata = wd;
        tick;
        in_valid = 1'b0; in_wen = 1'b0;
        chk({tag, ".awvalid"}, awvalid, 1);
        chk({tag, ".wvalid"}, wvalid, 1);
        chk({tag, ".arvalid"}, arvalid, 0);
        chk({tag, ".awaddr"}, awaddr, exp_awaddr);
        chk({tag, ".wdata"}, wdata, exp_wdata);
        chk({tag, ".wstrb"}, wstrb, exp_wstrb);
        awready = 1'b1; wready = 1'b1;
        tick;
        awready = 1'b0; wready = 1'b0;
        chk({tag, ".aw_w_drop"}, {awvalid, wvalid}, 0);
        chk({tag, ".bready"}, bready, 1);
        bvalid = 1'b1; bresp = br;
        tick;
        bvalid = 1'b0; bresp = 1'b0;
        chk({tag, ".bready_drop"}, bready, 0);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".out_err"}, out_err, {31'b0, br});
        chk({tag, ".out_rdata"}, out_rdata, 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, ".idle"}, in_ready, 1);
    endtask

    task automatic mis_op(input string tag, input logic wen, input logic [31:0] a, input logic [1:0] sz);
        in_valid = 1'b1; in_wen = wen; in_addr = a; in_size = sz; in_wdata = 32'h1111_2222;
        tick;
        in_valid = 1'b0; in_wen = 1'b0;
        chk({tag, ".no_bus"}, {arvalid, awvalid, wvalid}, 0);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".out_err"}, out_err, 1);
        chk({tag, ".out_rdata"}, out_rdata, 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, ".idle"}, in_ready, 1);
    endtask

    initial begin
        int aw_cnt, w_cnt, b_cnt;
        rst = 1'b0;
        in_valid = 0; in_wen = 0; in_addr = 0; in_wdata = 0; in_size = 0; in_unsigned = 0;
        out_ready = 0; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        #1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.valids", {arvalid, awvalid, wvalid, rready, bready, out_valid, out_err}, 0);
        chk("rst.out_rdata", out_rdata, 0);
        chk("rst.addr", araddr | awaddr, 0);
        chk("rst.wdata", wdata, 0);
        chk("rst.wstrb", wstrb, 0);
        #19 rst = 1'b1;
        tick;
        chk("post_rst.in_ready", in_ready, 1);

        load_op("ldb_s3",  32'h8000_0003, 2'd0, 1'b0, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_FF80);
        load_op("ldb_u1",  32'h8000_0001, 2'd0, 1'b1, 32'h80FF_1234, 32'h8000_0000, 32'h0000_0012);
        load_op("ldh_u2",  32'h8000_0002, 2'd1, 1'b1, 32'h80FF_1234, 32'h8000_0000, 32'h0000_80FF);
        load_op("ldh_s2",  32'h8000_0002, 2'd1, 1'b0, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_80FF);
        load_op("ldw",     32'h8000_0008, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h8000_0008, 32'hCAFE_F00D);
        load_op("ld_sz3",  32'h8000_0004, 2'd3, 1'b1, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);

        store_op("sth2", 32'h8000_0002, 2'd1, 32'h0000_ABCD, 1'b0, 32'h8000_0000, 32'hABCD_0000, 32'h0000_000C);
        store_op("stb1", 32'h8000_0001, 2'd0, 32'h0000_0055, 1'b0, 32'h8000_0000, 32'h0000_5500, 32'h0000_0002);
        store_op("stw_err", 32'h8000_0010, 2'd2, 32'h1234_5678, 1'b1, 32'h8000_0010, 32'h1234_5678, 32'h0000_000F);

        mis_op("mis_ldw2", 1'b0, 32'h8000_0002, 2'd2);
        mis_op("mis_sth1", 1'b1, 32'h8000_0001, 2'd1);
        mis_op("mis_sz3",  1'b0, 32'h8000_0001, 2'd3);

        // Store with awready delayed three cycles and wready immediate.
        in_valid = 1'b1; in_wen = 1'b1; in_addr = 32'h8000_0020; in_size = 2'd2; in_wdata = 32'hA5A5_5A5A;
        tick;
        in_valid = 1'b0; in_wen = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (awvalid) aw_cnt++;
            if (wvalid)  w_cnt++;
            if (bready)  b_cnt++;
            if (awvalid && arvalid) chk("dly.ar_aw_excl", 1, 0);
            awready = (k == 4);
            wready  = 1'b1;
            bvalid  = bready;
            tick;
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        chk("dly.wvalid_cycles", w_cnt, 1);
        chk("dly.awvalid_cycles", aw_cnt, 4);
        chk("dly.bready_cycles", b_cnt, 1);
        chk("dly.out_valid", out_valid, 1);
        chk("dly.out_err", out_err, 0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Load with error response, consumer stalls five cycles.
        in_valid = 1'b1; in_wen = 1'b0; in_addr = 32'h8000_0040; in_size = 2'd2; in_unsigned = 1'b0;
        tick;
        in_valid = 1'b0;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0BAD_0BAD; rresp = 1'b1;
        tick;
        rvalid = 1'b0; rresp = 1'b0; rdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk("stall.out_valid", out_valid, 1);
            chk("stall.out_err", out_err, 1);
            chk("stall.out_rdata", out_rdata, 32'h0BAD_0BAD);
            chk("stall.in_ready", in_ready, 0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("stall.release", {out_valid, in_ready}, 32'h1);

        // Reset asserted while waiting for read data.
        in_valid = 1'b1; in_wen = 1'b0; in_addr = 32'h8000_0050; in_size = 2'd2;
        tick;
        in_valid = 1'b0;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        chk("mid_rst.rready_before", rready, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst.rready", rready, 0);
        chk("mid_rst.out_valid", out_valid, 0);
        chk("mid_rst.in_ready", in_ready, 1);
        tick;
        chk("mid_rst.held_in_ready", in_ready, 1);
        chk("mid_rst.held_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("mid_rst.after_in_ready", in_ready, 1);
        load_op("ld_after_rst", 32'h8000_0060, 2'd0, 1'b1, 32'h0000_00F7, 32'h8000_0060, 32'h0000_00F7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
